ei_axi4_slave_mem: RTL
======================

EI_AXI4_SLAVE_MEM -- requirements
Module: ei_axi4_slave_mem

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bus width in bits (32 or 64).
REQ-002 Parameter ADDR_WIDTH, 32, address width in bits.
REQ-003 Parameter MEM_WORDS, 256, memory depth in DATA_WIDTH words.
REQ-004 aclk  input  1  single clock; all logic on rising edge.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 awaddr  input  ADDR_WIDTH  write burst start address.
REQ-007 awlen  input  8  write beats minus one.
REQ-008 awsize  input  3  log2 bytes per write beat.
REQ-009 awburst  input  burst_type_e  FIXED=0, INCR=1, WRAP=2.
REQ-010 awvalid / awready  input / output  1  write-address handshake.
REQ-011 wdata  input  DATA_WIDTH  write data.
REQ-012 wstrb  input  DATA_WIDTH/8  byte-lane enables.
REQ-013 wlast  input  1  final write beat marker.
REQ-014 wvalid / wready  input / output  1  write-data handshake.
REQ-015 bresp  output  response_e  OKAY=0, SLVERR=2.
REQ-016 bvalid / bready  output / input  1  write-response handshake.
REQ-017 araddr, arlen, arsize, arburst  input  ADDR_WIDTH/8/3/burst_type_e  read burst fields, same meaning as AW.
REQ-018 arvalid / arready  input / output  1  read-address handshake.
REQ-019 rdata  output  DATA_WIDTH  read data; rresp  output  response_e; rlast  output  1.
REQ-020 rvalid / rready  output / input  1  read-data handshake.

Function
REQ-021 Write FSM states W_IDLE, W_DATA, W_RESP; read FSM states R_IDLE, R_DATA; the two run independently and concurrently.
REQ-022 W_IDLE: awready=1; on awvalid&&awready latch AW fields, clear beat count and error flag, go W_DATA next cycle.
REQ-023 W_DATA: wready=1; each wvalid&&wready beat writes only lanes with wstrb=1 at current word index, then advances address and beat count.
REQ-024 Beat awlen+1 moves W_DATA->W_RESP; wlast not matching (beat==awlen) on any beat sets error flag; wlast never ends the burst early.
REQ-025 W_RESP: bvalid=1, bresp=SLVERR if error flag else OKAY; bresp stable until bvalid&&bready, then W_IDLE.
REQ-026 R_IDLE: arready=1; on handshake latch AR fields, go R_DATA; first rvalid the cycle after AR handshake.
REQ-027 R_DATA: rvalid=1, rdata = memory word at current address (0 when SLVERR), rlast=1 when beat==arlen; rdata/rresp/rlast stable while rvalid&&!rready.
REQ-028 On rvalid&&rready: advance beat; after rlast beat return to R_IDLE (arready=1 next cycle, no back-to-back overlap).
REQ-029 Word index = addr >> log2(DATA_WIDTH/8); index >= MEM_WORDS gives SLVERR for that beat/burst; out-of-range writes are dropped.
REQ-030 Beat bytes = 1<<size; size > log2(DATA_WIDTH/8), burst=3, or WRAP with len not in {1,3,7,15} gives SLVERR for the whole burst, no memory write.
REQ-031 Next address: FIXED unchanged; INCR addr+bytes, ADDR_WIDTH modulo; WRAP with boundary bytes*(len+1): next = (addr & ~(boundary-1)) | ((addr+bytes) & (boundary-1)).
REQ-032 Read and write to same word in same cycle: read returns pre-write data; write visible from next cycle.

Reset
REQ-033 While aresetn=0 at a rising edge: both FSMs to IDLE, awready=arready=wready=bvalid=rvalid=rlast=0, bresp=rresp=OKAY, rdata=0.
REQ-034 awready/arready go 1 on the first edge with aresetn=1; memory contents are not cleared; reset mid-burst abandons it with no B or R response.

Verification
REQ-035 INCR write awaddr=0x10, awlen=3, awsize=2, data 0xA0..0xA3, wstrb=0xF -> bresp=OKAY; INCR read of same -> 0xA0,0xA1,0xA2,0xA3, rlast on beat 4 only.
REQ-036 WRAP read araddr=0x18, arlen=3, arsize=2 -> word addresses 0x18,0x1C,0x10,0x14.
REQ-037 Write wstrb=0x3 data 0xDEADBEEF over 0x11223344 -> read returns 0x1122BEEF.
REQ-038 awaddr=MEM_WORDS*4 (=0x400) -> bresp=SLVERR, memory unchanged; read there -> rdata=0, rresp=SLVERR.
REQ-039 rready held 0 for 5 cycles mid-burst -> rdata/rlast stable; bready delayed 3 cycles -> bvalid, bresp held.
REQ-040 aresetn=0 during beat 2 of a 4-beat write -> no bvalid; awready=1 on the first edge after release; next burst completes OKAY.

Source files
------------

// File: rtl/ei_axi4_slave_mem.sv
// rtl/ei_axi4_slave_mem.sv - AXI4 burst slave backed by a word-addressed memory
//
// Purpose: accepts AXI4 write and read bursts (FIXED/INCR/WRAP) against an
// internal array of MEM_WORDS words. The write and read channels run as two
// independent FSMs and may be active in the same cycle.
//
// Ports:
//   aclk, aresetn                    clock, synchronous active-low reset
//   aw* (addr/len/size/burst/valid/ready)  write address channel
//   w*  (data/strb/last/valid/ready)       write data channel
//   b*  (resp/valid/ready)                 write response channel
//   ar* (addr/len/size/burst/valid/ready)  read address channel
//   r*  (data/resp/last/valid/ready)       read data channel

package ei_axi4_slave_mem_pkg;
  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3} burst_type_e;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} response_e;
endpackage

module ei_axi4_slave_mem
  import ei_axi4_slave_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 256
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  burst_type_e             awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output response_e               bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  burst_type_e             arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output response_e               rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int LANE_LOG = $clog2(STRB_W);
  localparam int IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Held low through reset and for the reset-release edge so the address
  // channels only open one edge after aresetn rises.
  logic live;

  function automatic logic burst_bad(input logic [2:0] size, input burst_type_e burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'(LANE_LOG)) || (burst == RSVD) || ((burst == WRAP) && !wrap_len_ok);
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> LANE_LOG) < ADDR_WIDTH'(MEM_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> LANE_LOG);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size,
                                                      input burst_type_e burst,
                                                      input logic [7:0] len);
    logic [ADDR_WIDTH-1:0] bytes, mask, n;
    bytes = ADDR_WIDTH'(1) << size;
    mask  = (bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1))) - ADDR_WIDTH'(1);
    case (burst)
      FIXED:   n = addr;
      WRAP:    n = (addr & ~mask) | ((addr + bytes) & mask);
      default: n = addr + bytes;
    endcase
    return n;
  endfunction

  // ---------------- state registers ----------------
  w_state_e w_state, w_next;
  r_state_e r_state, r_next;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      live    <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      live    <= 1'b1;
    end
  end

  // ---------------- write channel ----------------
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_beat;
  logic [2:0]            w_size;
  burst_type_e           w_burst;
  logic                  w_bad, w_err;
  logic                  aw_fire, w_fire, w_final, w_in_range;
  logic [IDX_W-1:0]      w_idx;

  assign aw_fire    = awvalid && awready;
  assign w_fire     = wvalid && wready;
  assign w_final    = (w_beat == w_len);
  assign w_in_range = in_range(w_addr);
  assign w_idx      = word_idx(w_addr);

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = OKAY;
    case (w_state)
      W_IDLE: begin
        awready = live;
        if (awvalid && live) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = (w_bad || w_err) ? SLVERR : OKAY;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= FIXED;
      w_beat  <= '0;
      w_bad   <= 1'b0;
      w_err   <= 1'b0;
    end else if (aw_fire) begin
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_beat  <= '0;
      w_bad   <= burst_bad(awsize, awburst, awlen);
      w_err   <= 1'b0;
    end else if (w_fire) begin
      // The beat count alone ends the burst; a misplaced wlast only taints bresp.
      if ((wlast != w_final) || (!w_bad && !w_in_range)) w_err <= 1'b1;
      w_addr <= next_addr(w_addr, w_size, w_burst, w_len);
      w_beat <= w_beat + 8'd1;
    end
  end

  // Memory is never cleared; a beat presented on a reset edge is discarded.
  always_ff @(posedge aclk) begin
    if (aresetn && w_fire && !w_bad && w_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  logic [ADDR_WIDTH-1:0] r_addr, f_addr;
  logic [7:0]            r_len, r_beat;
  logic [2:0]            r_size;
  burst_type_e           r_burst;
  logic                  r_bad, f_bad, f_ok;
  logic                  ar_fire, r_fire;
  logic [IDX_W-1:0]      f_idx;

  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = live;
        if (arvalid && live) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Address of the beat to be loaded into the registered R outputs at the
  // next edge: the AR address when idle, otherwise the successor beat.
  always_comb begin
    if (r_state == R_IDLE) begin
      f_addr = araddr;
      f_bad  = burst_bad(arsize, arburst, arlen);
    end else begin
      f_addr = next_addr(r_addr, r_size, r_burst, r_len);
      f_bad  = r_bad;
    end
  end

  assign f_ok  = !f_bad && in_range(f_addr);
  assign f_idx = word_idx(f_addr);

  // R outputs are registered, so they hold under backpressure and a same-edge
  // write to the fetched word is seen only by later beats.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= FIXED;
      r_beat  <= '0;
      r_bad   <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
      rlast   <= 1'b0;
    end else if (ar_fire) begin
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_bad   <= f_bad;
      r_beat  <= '0;
      rlast   <= (arlen == 8'd0);
      rdata   <= f_ok ? mem[f_idx] : '0;
      rresp   <= f_ok ? OKAY : SLVERR;
    end else if (r_fire) begin
      if (rlast) begin
        rlast <= 1'b0;
      end else begin
        r_addr <= f_addr;
        r_beat <= r_beat + 8'd1;
        rlast  <= ((r_beat + 8'd1) == r_len);
        rdata  <= f_ok ? mem[f_idx] : '0;
        rresp  <= f_ok ? OKAY : SLVERR;
      end
    end
  end

endmodule
